muntjac_dcache_bridge: RTL and testbench

MUNTJAC_DCACHE_BRIDGE -- requirements
Module: muntjac_dcache_bridge

---
 rtl/muntjac_pkg.sv | 26 ++
 rtl/muntjac_dcache_bridge_align.sv | 28 ++
 rtl/muntjac_dcache_bridge.sv | 110 +++++++++++
 tb/tb_muntjac_dcache_bridge.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muntjac_pkg.sv
// muntjac_pkg: memory op, extension and exception types shared by the data-cache path
package muntjac_pkg;
  typedef enum logic [2:0] {
    MEM_LOAD  = 3'd0,
    MEM_STORE = 3'd1,
    MEM_LR    = 3'd2,
    MEM_SC    = 3'd3,
    MEM_AMO   = 3'd4
  } mem_op_e;
  typedef enum logic [1:0] {
    SizeExtZero   = 2'd0,
    SizeExtSigned = 2'd1,
    SizeExtOne    = 2'd2
  } size_ext_e;
  typedef enum logic [3:0] {
    EXC_CAUSE_INSN_ADDR_MISA     = 4'd0,
    EXC_CAUSE_LOAD_MISALIGN      = 4'd4,
    EXC_CAUSE_LOAD_ACCESS_FAULT  = 4'd5,
    EXC_CAUSE_STORE_MISALIGN     = 4'd6,
    EXC_CAUSE_STORE_ACCESS_FAULT = 4'd7
  } exc_cause_e;
  typedef struct packed {
    exc_cause_e  cause;
    logic [63:0] tval;
  } exception_t;
endpackage

// File: rtl/muntjac_dcache_bridge_align.sv
// muntjac_dcache_bridge_align: byte-lane strobe/data placement and load extract/extend
module muntjac_dcache_bridge_align
  import muntjac_pkg::*;
(
  input  logic [2:0]  offset_i,
  input  logic [1:0]  size_i,
  input  size_ext_e   ext_i,
  input  logic [63:0] wvalue_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rvalue_o
);
  logic [7:0]  lanes;
  logic [63:0] shifted, mask, fill;
  logic        msb;
  // 8-bit wrap makes size 3 yield 8'hFF
  assign lanes   = (8'd1 << (4'd1 << size_i)) - 8'd1;
  assign wstrb_o = lanes << offset_i;
  assign wdata_o = wvalue_i << {offset_i, 3'b000};
  assign shifted = rdata_i >> {offset_i, 3'b000};
  always_comb begin
    mask     = size_i == 2'd0 ? 64'hFF : size_i == 2'd1 ? 64'hFFFF : size_i == 2'd2 ? 64'hFFFF_FFFF : '1;
    msb      = size_i == 2'd0 ? shifted[7] : size_i == 2'd1 ? shifted[15] : size_i == 2'd2 ? shifted[31] : shifted[63];
    fill     = ext_i == SizeExtSigned ? {64{msb}} : ext_i == SizeExtOne ? '1 : '0;
    rvalue_o = (shifted & mask) | (fill & ~mask);
  end
endmodule

// File: rtl/muntjac_dcache_bridge.sv
// muntjac_dcache_bridge: single-outstanding bridge from the pipeline dcache port to a simple memory bus
module muntjac_dcache_bridge
  import muntjac_pkg::*;
#(
  parameter int PhysAddrWidth = 56
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dcache_req_valid,
  output logic        dcache_req_ready,
  input  logic [63:0] dcache_req_address,
  input  logic [63:0] dcache_req_value,
  input  mem_op_e     dcache_req_op,
  input  logic [1:0]  dcache_req_size,
  input  size_ext_e   dcache_req_size_ext,
  output logic        dcache_resp_valid,
  output logic [63:0] dcache_resp_value,
  output logic        dcache_ex_valid,
  output exception_t  dcache_ex_exception,
  input  logic        dcache_notif_valid,
  input  logic        dcache_notif_reason,
  output logic        dcache_notif_ready,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata
);
  localparam logic [1:0] IDLE = 2'd0, MEM_REQ = 2'd1, MEM_WAIT = 2'd2, EXC = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [63:0] addr_q, value_q, resp_value_q, load_value;
  mem_op_e     op_q;
  logic [1:0]  size_q;
  size_ext_e   ext_q;
  exc_cause_e  cause_q, cause_d;
  logic        resp_valid_q, ex_valid_q;
  logic        accept, is_load, misa, oor, bad, mem_done;
  logic        unused_notif_reason;
  assign unused_notif_reason = dcache_notif_reason;
  assign dcache_req_ready   = state_q == IDLE && !dcache_notif_valid;
  assign dcache_notif_ready = state_q == IDLE;
  assign accept   = dcache_req_valid && dcache_req_ready;
  assign mem_done = state_q == MEM_WAIT && mem_resp_valid;
  assign is_load  = dcache_req_op == MEM_LOAD;
  assign misa     = |(dcache_req_address[2:0] & ((3'd1 << dcache_req_size) - 3'd1));
  assign oor      = |(dcache_req_address >> PhysAddrWidth);
  assign bad      = misa || oor || !(is_load || dcache_req_op == MEM_STORE);
  // Misalignment wins over range; unsupported ops report as store access faults
  always_comb begin
    cause_d = misa ? (is_load ? EXC_CAUSE_LOAD_MISALIGN : EXC_CAUSE_STORE_MISALIGN) :
              oor  ? (is_load ? EXC_CAUSE_LOAD_ACCESS_FAULT : EXC_CAUSE_STORE_ACCESS_FAULT) :
                     EXC_CAUSE_STORE_ACCESS_FAULT;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = bad ? EXC : MEM_REQ;
      MEM_REQ:  if (mem_req_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_resp_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      value_q      <= '0;
      op_q         <= MEM_LOAD;
      size_q       <= '0;
      ext_q        <= SizeExtZero;
      cause_q      <= EXC_CAUSE_INSN_ADDR_MISA;
      resp_valid_q <= 1'b0;
      ex_valid_q   <= 1'b0;
      resp_value_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= mem_done;
      ex_valid_q   <= state_q == EXC;
      if (accept) begin
        addr_q  <= dcache_req_address;
        value_q <= dcache_req_value;
        op_q    <= dcache_req_op;
        size_q  <= dcache_req_size;
        ext_q   <= dcache_req_size_ext;
        cause_q <= cause_d;
      end
      if (mem_done) resp_value_q <= op_q == MEM_LOAD ? load_value : '0;
    end
  end
  muntjac_dcache_bridge_align u_align (
    .offset_i (addr_q[2:0]),
    .size_i   (size_q),
    .ext_i    (ext_q),
    .wvalue_i (value_q),
    .rdata_i  (mem_resp_rdata),
    .wstrb_o  (mem_req_wstrb),
    .wdata_o  (mem_req_wdata),
    .rvalue_o (load_value)
  );
  assign mem_req_valid       = state_q == MEM_REQ;
  assign mem_req_addr        = {addr_q[63:3], 3'b000};
  assign mem_req_we          = op_q == MEM_STORE;
  assign dcache_resp_valid   = resp_valid_q;
  assign dcache_resp_value   = resp_value_q;
  assign dcache_ex_valid     = ex_valid_q;
  assign dcache_ex_exception = '{cause: cause_q, tval: addr_q};
endmodule

// File: tb/tb_muntjac_dcache_bridge.sv
// tb_muntjac_dcache_bridge: vector table plus directed backpressure/reset sequences
module tb_muntjac_dcache_bridge;
  import muntjac_pkg::*;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        dcache_req_valid = 1'b0, dcache_req_ready;
  logic [63:0] dcache_req_address = '0, dcache_req_value = '0;
  mem_op_e     dcache_req_op = MEM_LOAD;
  logic [1:0]  dcache_req_size = '0;
  size_ext_e   dcache_req_size_ext = SizeExtZero;
  logic        dcache_resp_valid, dcache_ex_valid;
  logic [63:0] dcache_resp_value;
  exception_t  dcache_ex_exception;
  logic        dcache_notif_valid = 1'b0, dcache_notif_reason = 1'b0, dcache_notif_ready;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_rdata = '0;
  int checks = 0, errors = 0;

  muntjac_dcache_bridge #(.PhysAddrWidth(56)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_req_address(dcache_req_address), .dcache_req_value(dcache_req_value),
    .dcache_req_op(dcache_req_op), .dcache_req_size(dcache_req_size),
    .dcache_req_size_ext(dcache_req_size_ext),
    .dcache_resp_valid(dcache_resp_valid), .dcache_resp_value(dcache_resp_value),
    .dcache_ex_valid(dcache_ex_valid), .dcache_ex_exception(dcache_ex_exception),
    .dcache_notif_valid(dcache_notif_valid), .dcache_notif_reason(dcache_notif_reason),
    .dcache_notif_ready(dcache_notif_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    mem_op_e     op;
    logic [1:0]  size;
    size_ext_e   ext;
    logic [63:0] addr;
    logic [63:0] value;
    logic [63:0] rdata;
    logic        ex;
    exc_cause_e  cause;
    logic [63:0] resp;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int seen;
    v = vecs[i];
    seen = 0;
    @(negedge clk_i);
    check($sformatf("v%0d ready", i), 64'(dcache_req_ready), 64'd1);
    dcache_req_op = v.op; dcache_req_size = v.size; dcache_req_size_ext = v.ext;
    dcache_req_address = v.addr; dcache_req_value = v.value; dcache_req_valid = 1'b1;
    @(negedge clk_i);
    dcache_req_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (dcache_resp_valid || dcache_ex_valid) break;
      if (mem_req_valid) begin
        seen++;
        check($sformatf("v%0d addr", i), mem_req_addr, {v.addr[63:3], 3'b000});
        check($sformatf("v%0d we", i), 64'(mem_req_we), 64'(v.op == MEM_STORE));
        check($sformatf("v%0d wstrb", i), 64'(mem_req_wstrb), 64'(v.wstrb));
        check($sformatf("v%0d wdata", i), mem_req_wdata, v.wdata);
        mem_req_ready = 1'b1;
        @(negedge clk_i);
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = v.rdata;
        @(negedge clk_i);
        mem_resp_valid = 1'b0;
      end else @(negedge clk_i);
    end
    check($sformatf("v%0d done", i), 64'(dcache_resp_valid || dcache_ex_valid), 64'd1);
    check($sformatf("v%0d exv", i), 64'(dcache_ex_valid), 64'(v.ex));
    check($sformatf("v%0d respv", i), 64'(dcache_resp_valid), 64'(!v.ex));
    check($sformatf("v%0d memtx", i), 64'(seen), v.ex ? 64'd0 : 64'd1);
    check($sformatf("v%0d rdy_at_resp", i), 64'(dcache_req_ready), 64'd1);
    if (v.ex) begin
      check($sformatf("v%0d cause", i), 64'(dcache_ex_exception.cause), 64'(v.cause));
      check($sformatf("v%0d tval", i), dcache_ex_exception.tval, v.addr);
    end else check($sformatf("v%0d resp", i), dcache_resp_value, v.resp);
    @(negedge clk_i);
    check($sformatf("v%0d pulse", i), 64'(dcache_resp_valid || dcache_ex_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{MEM_LOAD,  2'd3, SizeExtZero,   64'h1000, 64'h0, 64'h8877665544332211, 1'b0, EXC_CAUSE_INSN_ADDR_MISA, 64'h8877665544332211, 8'hFF, 64'h0};
    vecs[1]  = '{MEM_LOAD,  2'd0, SizeExtSigned, 64'h1003, 64'h0, 64'h0000000080000000, 1'b0, EXC_CAUSE_INSN_ADDR_MISA, 64'hFFFFFFFFFFFFFF80, 8'h08, 64'h0};
    vecs[2]  = '{MEM_LOAD,  2'd0, SizeExtZero,   64'h1003, 64'h0, 64'h0000000080000000, 1'b0, EXC_CAUSE_INSN_ADDR_MISA, 64'h80, 8'h08, 64'h0};
    vecs[3]  = '{MEM_STORE, 2'd1, SizeExtZero,   64'h2006, 64'hABCD, 64'hDEADBEEFDEADBEEF, 1'b0, EXC_CAUSE_INSN_ADDR_MISA, 64'h0, 8'hC0, 64'hABCD000000000000};
    vecs[4]  = '{MEM_LOAD,  2'd2, SizeExtZero,   64'h1002, 64'h0, 64'h0, 1'b1, EXC_CAUSE_LOAD_MISALIGN, 64'h0, 8'h0, 64'h0};
    vecs[5]  = '{MEM_LOAD,  2'd2, SizeExtOne,    64'h3004, 64'h0, 64'h1234567800000000, 1'b0, EXC_CAUSE_INSN_ADDR_MISA, 64'hFFFFFFFF12345678, 8'hF0, 64'h0};
    vecs[6]  = '{MEM_LOAD,  2'd1, SizeExtSigned, 64'h3002, 64'h0, 64'h000000007FFF0000, 1'b0, EXC_CAUSE_INSN_ADDR_MISA, 64'h7FFF, 8'h0C, 64'h0};
    vecs[7]  = '{MEM_STORE, 2'd3, SizeExtZero,   64'h2004, 64'h1, 64'h0, 1'b1, EXC_CAUSE_STORE_MISALIGN, 64'h0, 8'h0, 64'h0};
    vecs[8]  = '{MEM_LOAD,  2'd3, SizeExtZero,   64'h0100000000000000, 64'h0, 64'h0, 1'b1, EXC_CAUSE_LOAD_ACCESS_FAULT, 64'h0, 8'h0, 64'h0};
    vecs[9]  = '{MEM_STORE, 2'd2, SizeExtZero,   64'h8000000000000000, 64'h0, 64'h0, 1'b1, EXC_CAUSE_STORE_ACCESS_FAULT, 64'h0, 8'h0, 64'h0};
    vecs[10] = '{MEM_AMO,   2'd3, SizeExtZero,   64'h1000, 64'h0, 64'h0, 1'b1, EXC_CAUSE_STORE_ACCESS_FAULT, 64'h0, 8'h0, 64'h0};
    vecs[11] = '{MEM_LR,    2'd1, SizeExtZero,   64'h1001, 64'h0, 64'h0, 1'b1, EXC_CAUSE_STORE_MISALIGN, 64'h0, 8'h0, 64'h0};
    vecs[12] = '{MEM_STORE, 2'd0, SizeExtZero,   64'h1007, 64'h5A, 64'h0, 1'b0, EXC_CAUSE_INSN_ADDR_MISA, 64'h0, 8'h80, 64'h5A00000000000000};
    vecs[13] = '{MEM_LOAD,  2'd3, SizeExtZero,   64'h00FFFFFFFFFFFFF8, 64'h0, 64'h0123456789ABCDEF, 1'b0, EXC_CAUSE_INSN_ADDR_MISA, 64'h0123456789ABCDEF, 8'hFF, 64'h0};

    repeat (3) @(negedge clk_i);
    check("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst resp_valid", 64'(dcache_resp_valid), 64'd0);
    check("rst ex_valid", 64'(dcache_ex_valid), 64'd0);
    check("rst resp_value", dcache_resp_value, 64'd0);
    check("rst ex_exception", 64'(dcache_ex_exception.cause) | dcache_ex_exception.tval, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post-rst ready", 64'(dcache_req_ready), 64'd1);

    for (int i = 0; i < 14; i++) run_vec(i);

    // Notification priority followed by a backpressured load
    @(negedge clk_i);
    dcache_notif_valid = 1'b1;
    dcache_req_op = MEM_LOAD; dcache_req_size = 2'd3; dcache_req_size_ext = SizeExtZero;
    dcache_req_address = 64'h4008; dcache_req_value = 64'h0; dcache_req_valid = 1'b1;
    #1;
    check("notif blocks req_ready", 64'(dcache_req_ready), 64'd0);
    check("notif_ready", 64'(dcache_notif_ready), 64'd1);
    @(negedge clk_i);
    dcache_notif_valid = 1'b0;
    #1;
    check("notif left idle", 64'(dcache_notif_ready), 64'd1);
    check("req_ready after notif", 64'(dcache_req_ready), 64'd1);
    @(negedge clk_i);
    dcache_req_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      check("bp valid", 64'(mem_req_valid), 64'd1);
      check("bp addr", mem_req_addr, 64'h4008);
      check("bp wstrb", 64'(mem_req_wstrb), 64'hFF);
      check("bp we", 64'(mem_req_we), 64'd0);
      @(negedge clk_i);
    end
    mem_req_ready = 1'b1;
    @(negedge clk_i);
    mem_req_ready = 1'b0;
    check("bp single tx", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h55;
    @(negedge clk_i);
    mem_resp_valid = 1'b0;
    check("bp resp_valid", 64'(dcache_resp_valid), 64'd1);
    check("bp resp_value", dcache_resp_value, 64'h55);

    // Stray memory response while idle
    @(negedge clk_i);
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h99;
    @(negedge clk_i);
    mem_resp_valid = 1'b0;
    check("stray resp ignored", 64'(dcache_resp_valid), 64'd0);
    check("stray keeps value", dcache_resp_value, 64'h55);
    @(negedge clk_i);
    check("stray resp ignored 2", 64'(dcache_resp_valid), 64'd0);

    // Reset while waiting for memory
    dcache_req_address = 64'h5000; dcache_req_valid = 1'b1;
    @(negedge clk_i);
    dcache_req_valid = 1'b0;
    check("rw mem_req_valid", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk_i);
    mem_req_ready = 1'b0;
    check("rw in wait", 64'(mem_req_valid | dcache_req_ready), 64'd0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("rw rst mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rw rst resp_value", dcache_resp_value, 64'd0);
    check("rw rst resp_valid", 64'(dcache_resp_valid), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rw ready after release", 64'(dcache_req_ready), 64'd1);
    for (int n = 0; n < 5; n++) begin
      check("rw no resp", 64'(dcache_resp_valid | dcache_ex_valid), 64'd0);
      @(negedge clk_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
